single_max_reduce: RTL and testbench

Streaming consumer for IEEE-754 single-precision operand streams. It accepts one 32-bit word per cycle over a valid/ready handshake, keeps a running maximum with the same ordering rules as `single_max`, and emits one result per packet: the maximum and the element count. The packet end is marked by `in_last`. The block sits on the operand-consumption side of the math components. It folds a stream down to a single value instead of comparing one fixed pair of operands.

---
 rtl/single_max_reduce.sv | 176 +++++++++++++++++
 tb/tb_single_max_reduce.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/single_max_reduce.sv
// single_max_reduce: folds a packet of IEEE-754 single-precision words into
// one result holding the packet maximum and the number of words seen.
//
// Handshake (both sides): a word moves across an interface on a rising edge
// where valid && ready are both high. The producer holds data (and in_last)
// stable while valid is high and ready is low; valid, once raised, is not
// withdrawn before the transfer. out_valid stays high until out_ready takes it.
module single_max_reduce #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [31:0]        out_data,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               dbg_state
);

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    typedef enum logic {
        ACCEPT = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          acc_q, acc_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic [31:0]          out_data_q, out_data_d;
    logic [COUNT_W-1:0]   out_count_q, out_count_d;
    logic                 out_valid_q, out_valid_d;

    // Combinational helpers for the fold step.
    logic                 in_xfer;
    logic                 out_xfer;
    logic [31:0]          fold_val;
    logic [COUNT_W-1:0]   cnt_next;

    // NaN: all-ones exponent with a non-zero mantissa (infinities excluded).
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Any NaN collapses to the canonical quiet NaN; other values pass through.
    function automatic logic [31:0] canon(input logic [31:0] x);
        return is_nan(x) ? CANON_NAN : x;
    endfunction

    // Sign-magnitude "a is at least b" for two non-NaN values.
    // Opposite signs: the positive one wins, so +0 beats -0.
    // Both positive: larger magnitude wins. Both negative: smaller magnitude wins.
    function automatic logic ge_num(input logic [31:0] a, input logic [31:0] b);
        logic res;
        if (a[31] != b[31]) begin
            res = ~a[31];
        end else if (!a[31]) begin
            res = (a[30:0] >= b[30:0]);
        end else begin
            res = (a[30:0] <= b[30:0]);
        end
        return res;
    endfunction

    // Pairwise max with NaN rules: a lone NaN loses to the other operand,
    // two NaNs give the canonical quiet NaN. A canonical-NaN accumulator is
    // therefore displaced by the next ordinary word.
    function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan;
        logic        b_nan;
        logic [31:0] res;
        a_nan = is_nan(a);
        b_nan = is_nan(b);
        if (a_nan && b_nan) begin
            res = CANON_NAN;
        end else if (a_nan) begin
            res = b;
        end else if (b_nan) begin
            res = a;
        end else if (ge_num(a, b)) begin
            res = a;
        end else begin
            res = b;
        end
        return res;
    endfunction

    // in_ready depends on the registered state only; no path from out_ready.
    assign in_ready  = (state_q == ACCEPT);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;
    assign dbg_state = state_q;

    assign in_xfer  = in_valid && (state_q == ACCEPT);
    assign out_xfer = out_valid_q && out_ready;

    // Value the accumulator and counter take if the current word is consumed.
    // The first word is canonicalised so a one-word NaN packet reports 0x7FC00000.
    always_comb begin
        fold_val = acc_q;
        cnt_next = cnt_q;
        if (first_q) begin
            fold_val = canon(in_data);
            cnt_next = COUNT_W'(1);
        end else begin
            fold_val = fmax(acc_q, in_data);
            cnt_next = (&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1);
        end
    end

    // Next-state and datapath update for the ACCEPT/OUTPUT controller.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ACCEPT: begin
                if (in_xfer) begin
                    acc_d   = fold_val;
                    cnt_d   = cnt_next;
                    first_d = 1'b0;
                    if (in_last) begin
                        out_data_d  = fold_val;
                        out_count_d = cnt_next;
                        out_valid_d = 1'b1;
                        state_d     = OUTPUT;
                    end
                end
            end
            OUTPUT: begin
                // Input side is closed; result registers hold until taken.
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    first_d     = 1'b1;
                    state_d     = ACCEPT;
                end
            end
            default: begin
                state_d = ACCEPT;
            end
        endcase
    end

    // State and datapath registers; reset wins over any same-cycle transfer
    // and drops any partially accumulated packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCEPT;
            acc_q       <= 32'h0000_0000;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            out_data_q  <= 32'h0000_0000;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_single_max_reduce.sv
// Bench for single_max_reduce: directed packets with timing checks, then
// random back-to-back packets against a reference built on an integer
// total-order key. A COUNT_W=4 copy shares the stimulus to cover saturation.
module tb_single_max_reduce;

    localparam int SB_W = 32 + 16 + 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        out_valid;
    logic        dbg_state;

    logic        s_in_ready;
    logic [31:0] s_out_data;
    logic [3:0]  s_out_count;
    logic        s_out_valid;
    logic        s_dbg_state;

    always #5 clk = ~clk;

    single_max_reduce #(.COUNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
        .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready),
        .dbg_state(dbg_state)
    );

    single_max_reduce #(.COUNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(s_in_ready), .out_data(s_out_data),
        .out_count(s_out_count), .out_valid(s_out_valid), .out_ready(out_ready),
        .dbg_state(s_dbg_state)
    );

    int n_checks = 0;
    int n_bad    = 0;
    bit sb_en    = 1'b0;

    logic [31:0]   pkt_q[$];
    logic [SB_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    // Monotonic unsigned key: negatives inverted, positives offset above them.
    function automatic logic [31:0] ref_key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    // Max over the non-NaN words; canonical NaN if every word is NaN.
    function automatic logic [31:0] ref_max();
        logic [31:0] best = '0;
        bit          have = 1'b0;
        foreach (pkt_q[i]) begin
            if (!ref_is_nan(pkt_q[i])) begin
                if (!have || ref_key(pkt_q[i]) > ref_key(best)) best = pkt_q[i];
                have = 1'b1;
            end
        end
        return have ? best : 32'h7FC0_0000;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] specials [11] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000,
            32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0001, 32'hFF80_0001,
            32'h0000_0001, 32'h8000_0001, 32'h3F80_0000, 32'hBF80_0000};
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 10)];
        return $urandom;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [31:0] d, input logic last);
        bit done = 1'b0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) check("in_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send pkt_q with out_ready high; check result and the one-cycle gap.
    task automatic run_pkt(input string tag, input logic [31:0] exp_d, input logic [15:0] exp_c);
        out_ready = 1'b1;
        for (int i = 0; i < pkt_q.size(); i++) push_word(pkt_q[i], i == pkt_q.size() - 1);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp_d));
        check({tag, "_count"}, 64'(out_count), 64'(exp_c));
        check({tag, "_gap"}, 64'(in_ready), 64'd0);
        @(negedge clk);
        check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (sb_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("rnd_unexpected", 64'd1, 64'd0);
            end else begin
                logic [SB_W-1:0] e;
                e = exp_q.pop_front();
                check("rnd_data", 64'(out_data), 64'(e[51:20]));
                check("rnd_count", 64'(out_count), 64'(e[19:4]));
                check("rnd_s_data", 64'(s_out_data), 64'(e[51:20]));
                check("rnd_s_count", 64'(s_out_count), 64'(e[3:0]));
                check("rnd_s_valid", 64'(s_out_valid), 64'd1);
            end
        end
    end

    always @(posedge clk) begin
        if (sb_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic packet
        pkt_q = '{32'h3F80_0000, 32'hC040_0000, 32'h4000_0000};
        run_pkt("t1", 32'h4000_0000, 16'd3);

        // Signed zeros
        pkt_q = '{32'hBF80_0000, 32'h8000_0000, 32'h0000_0000};
        run_pkt("t2a", 32'h0000_0000, 16'd3);
        pkt_q = '{32'h8000_0000, 32'hBF80_0000};
        run_pkt("t2b", 32'h8000_0000, 16'd2);

        // NaN handling
        pkt_q = '{32'h7FC0_0001, 32'hC040_0000};
        run_pkt("t3a", 32'hC040_0000, 16'd2);
        pkt_q = '{32'h7FC0_0001, 32'hFF80_0001};
        run_pkt("t3b", 32'h7FC0_0000, 16'd2);
        pkt_q = '{32'h7F80_0001};
        run_pkt("t3c", 32'h7FC0_0000, 16'd1);
        pkt_q = '{32'h7FC0_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        run_pkt("t3d", 32'h0000_0001, 16'd3);

        // Backpressure with in_valid pushed against a closed input
        out_ready = 1'b0;
        push_word(32'h3F80_0000, 1'b0);
        push_word(32'h4040_0000, 1'b1);
        in_valid = 1'b1; in_data = 32'h7F80_0000; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_valid", 64'(out_valid), 64'd1);
            check("t4_data", 64'(out_data), 64'h4040_0000);
            check("t4_count", 64'(out_count), 64'd2);
            check("t4_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t4_ready_back", 64'(in_ready), 64'd1);
        check("t4_valid_drop", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        pkt_q = '{32'hC000_0000, 32'hC080_0000};
        run_pkt("t4_next", 32'hC000_0000, 16'd2);

        // Reset in the middle of a packet, with a word offered in the same cycle
        push_word(32'h3F80_0000, 1'b0);
        push_word(32'h4000_0000, 1'b0);
        in_valid = 1'b1; in_data = 32'h4080_0000; in_last = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_data", 64'(out_data), 64'd0);
        check("t5_out_count", 64'(out_count), 64'd0);
        @(posedge clk);
        #1;
        pkt_q = '{32'h7F80_0000};
        run_pkt("t5_after", 32'h7F80_0000, 16'd1);

        // Random back-to-back packets; first one is 20 words long
        sb_en = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            logic [31:0] m;
            len = (p == 0) ? 20 : int'($urandom_range(1, 20));
            pkt_q.delete();
            for (int i = 0; i < len; i++) pkt_q.push_back(rand_word());
            m = ref_max();
            exp_q.push_back({m, 16'(len), 4'((len > 15) ? 15 : len)});
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                push_word(pkt_q[i], i == len - 1);
            end
        end
        for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clk);
        check("rnd_drain", 64'(exp_q.size()), 64'd0);
        sb_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
